// File: rtl/thinning_engine_if.sv
// Load/result stream bundle for thinning_engine; slave = engine side, master = producer/consumer side.
// THINNING_STATS_EN adds removed_count_out and its ADDR_WIDTH parameter.
interface thinning_engine_if #(
    parameter int HWIDTH = 9,
    parameter int VWIDTH = 8
`ifdef THINNING_STATS_EN
    , parameter int ADDR_WIDTH = 16
`endif
);
    logic [HWIDTH-1:0] hcount_in;
    logic [VWIDTH-1:0] vcount_in;
    logic              pixel_in;
    logic              pixel_valid_in;
    logic [1:0]        mode_in;
    logic              pixel_out;
    logic              pixel_valid_out;
    logic [HWIDTH-1:0] hcount_out;
    logic [VWIDTH-1:0] vcount_out;
    logic              busy_out;
    logic [7:0]        pass_count_out;
    logic              converged_out;
`ifdef THINNING_STATS_EN
    logic [ADDR_WIDTH:0] removed_count_out;
`endif

    modport slave (
`ifdef THINNING_STATS_EN
        output removed_count_out,
`endif
        input  hcount_in, vcount_in, pixel_in, pixel_valid_in, mode_in,
        output pixel_out, pixel_valid_out, hcount_out, vcount_out,
        output busy_out, pass_count_out, converged_out
    );

    modport master (
`ifdef THINNING_STATS_EN
        input  removed_count_out,
`endif
        output hcount_in, vcount_in, pixel_in, pixel_valid_in, mode_in,
        input  pixel_out, pixel_valid_out, hcount_out, vcount_out,
        input  busy_out, pass_count_out, converged_out
    );
endinterface

// File: rtl/thinning_engine.sv
// Binary frame engine (Zhang-Suen thinning / erode / dilate / copy) over ping/pong frame buffers.
// Pass latency H*V + H + 2 cycles (fixed depth H+2); THINNING_STATS_EN adds removed_count_out.
module thinning_engine #(
    parameter int HORIZONTAL_COUNT = 320,
    parameter int VERTICAL_COUNT   = 180,
    parameter int MAX_PASSES       = 32,
    parameter int MORPH_PASSES     = 1,
    localparam int HWIDTH     = $clog2(HORIZONTAL_COUNT),
    localparam int VWIDTH     = $clog2(VERTICAL_COUNT),
    localparam int ADDR_WIDTH = $clog2(HORIZONTAL_COUNT * VERTICAL_COUNT)
) (
    input logic              clk_in,
    input logic              rst_n_in,
    thinning_engine_if.slave bus
);
    localparam int H   = HORIZONTAL_COUNT;
    localparam int V   = VERTICAL_COUNT;
    localparam int N   = H * V;
    localparam int RCW = $clog2(N + H + 1);
    localparam logic [RCW-1:0]        RD_LAST   = RCW'(N + H);
    localparam logic [RCW-1:0]        WIN_START = RCW'(H + 1);
    localparam logic [RCW-1:0]        N_R       = RCW'(N);
    localparam logic [HWIDTH-1:0]     X_LAST    = HWIDTH'(H - 1);
    localparam logic [VWIDTH-1:0]     Y_LAST    = VWIDTH'(V - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST    = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {LOAD, PASS, DRAIN, EMIT} state_t;

    state_t                state;
    logic [1:0]            sync_q;
    logic [N-1:0]          buf0, buf1, src;
    logic                  src_sel;
    logic [1:0]            mode_q;
    logic [RCW-1:0]        rd_cnt;
    logic [2*H+2:0]        win;
    logic                  wr_vld, chg_any;
    logic [HWIDTH-1:0]     cx, ex;
    logic [VWIDTH-1:0]     cy, ey;
    logic [ADDR_WIDTH-1:0] wa, ea, ld_addr;
`ifdef THINNING_STATS_EN
    logic [ADDR_WIDTH:0]   chg_cnt;
`endif

    logic       rd_bit, ld_hit, ld_last;
    logic       lft, rgt, top, bot, p1;
    logic [7:0] ring;
    logic [3:0] nb, na;
    logic       thin_del, new_pix, pix_chg, chg_final, done;
    logic [7:0] pc_next;

    assign src     = src_sel ? buf1 : buf0;
    assign rd_bit  = (rd_cnt < N_R) ? src[rd_cnt[ADDR_WIDTH-1:0]] : 1'b0;
    assign ld_hit  = (state == LOAD) && sync_q[1] && bus.pixel_valid_in &&
                     (int'(bus.hcount_in) < H) && (int'(bus.vcount_in) < V);
    assign ld_last = ld_hit && (bus.hcount_in == X_LAST) && (bus.vcount_in == Y_LAST);
    assign ld_addr = ADDR_WIDTH'(int'(bus.vcount_in) * H + int'(bus.hcount_in));

    // win[0] is the newest stream bit; the centre sits H+1 bits back. Out-of-frame taps are masked.
    assign lft = (cx != '0);
    assign rgt = (cx != X_LAST);
    assign top = (cy != '0);
    assign bot = (cy != Y_LAST);
    assign p1  = win[H+1];
    assign ring = {top & lft & win[2*H+2],   // P9 NW
                   lft & win[H+2],           // P8 W
                   bot & lft & win[2],       // P7 SW
                   bot & win[1],             // P6 S
                   bot & rgt & win[0],       // P5 SE
                   rgt & win[H],             // P4 E
                   top & rgt & win[2*H],     // P3 NE
                   top & win[2*H+1]};        // P2 N

    always_comb begin
        nb = '0;
        na = '0;
        for (int k = 0; k < 8; k++) begin
            nb = nb + 4'(ring[k]);
            na = na + 4'(!ring[k] && ring[(k+1)%8]);
        end
        thin_del = p1 && (nb >= 4'd2) && (nb <= 4'd6) && (na == 4'd1) &&
                   (bus.pass_count_out[0] ? (!(ring[0] & ring[2] & ring[6]) && !(ring[0] & ring[4] & ring[6]))
                                          : (!(ring[0] & ring[2] & ring[4]) && !(ring[2] & ring[4] & ring[6])));
        case (mode_q)
            2'd0:    new_pix = p1 & !thin_del;
            2'd1:    new_pix = p1 & (&ring);
            2'd2:    new_pix = p1 | (|ring);
            default: new_pix = p1;
        endcase
    end

    assign pix_chg   = wr_vld && (new_pix != p1);
    assign chg_final = chg_any | pix_chg;
    assign pc_next   = bus.pass_count_out + 8'd1;
    assign done      = (mode_q == 2'd0) ? (!chg_final || pc_next == 8'(MAX_PASSES)) :
                       (mode_q == 2'd3) ? 1'b1 : (pc_next == 8'(MORPH_PASSES));

    always_ff @(posedge clk_in) begin
        if (ld_hit) buf0[ld_addr] <= bus.pixel_in;
        if (wr_vld) begin
            if (src_sel) buf0[wa] <= new_pix;
            else         buf1[wa] <= new_pix;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= LOAD;
            sync_q  <= '0;
            src_sel <= 1'b0;
            mode_q  <= '0;
            rd_cnt  <= '0;
            win     <= '0;
            wr_vld  <= 1'b0;
            chg_any <= 1'b0;
            cx <= '0; cy <= '0; wa <= '0;
            ex <= '0; ey <= '0; ea <= '0;
            bus.pixel_out       <= 1'b0;
            bus.pixel_valid_out <= 1'b0;
            bus.hcount_out      <= '0;
            bus.vcount_out      <= '0;
            bus.busy_out        <= 1'b0;
            bus.pass_count_out  <= '0;
            bus.converged_out   <= 1'b0;
`ifdef THINNING_STATS_EN
            chg_cnt               <= '0;
            bus.removed_count_out <= '0;
`endif
        end else begin
            sync_q              <= {sync_q[0], 1'b1};
            bus.pixel_valid_out <= 1'b0;
            bus.pixel_out       <= 1'b0;
            bus.hcount_out      <= '0;
            bus.vcount_out      <= '0;
            case (state)
                LOAD: begin
                    bus.busy_out <= 1'b0;
                    if (ld_last) begin
                        mode_q  <= bus.mode_in;
                        src_sel <= 1'b0;
                        rd_cnt  <= '0;
                        chg_any <= 1'b0;
                        cx <= '0; cy <= '0; wa <= '0;
                        bus.busy_out       <= 1'b1;
                        bus.pass_count_out <= '0;
                        bus.converged_out  <= 1'b0;
`ifdef THINNING_STATS_EN
                        chg_cnt               <= '0;
                        bus.removed_count_out <= '0;
`endif
                        state <= PASS;
                    end
                end
                PASS: begin
                    win    <= {win[2*H+1:0], rd_bit};
                    rd_cnt <= rd_cnt + 1'b1;
                    wr_vld <= (rd_cnt >= WIN_START);
                    if (wr_vld) begin
                        wa      <= wa + 1'b1;
                        chg_any <= chg_final;
`ifdef THINNING_STATS_EN
                        chg_cnt <= chg_cnt + (ADDR_WIDTH+1)'(pix_chg);
`endif
                        if (cx == X_LAST) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                    if (rd_cnt == RD_LAST) state <= DRAIN;
                end
                DRAIN: begin
                    // Final centre is written to the buffer on this edge; its change bit joins chg_final.
                    wr_vld  <= 1'b0;
                    src_sel <= ~src_sel;
                    chg_any <= 1'b0;
                    rd_cnt  <= '0;
                    cx <= '0; cy <= '0; wa <= '0;
                    bus.pass_count_out <= pc_next;
`ifdef THINNING_STATS_EN
                    chg_cnt               <= '0;
                    bus.removed_count_out <= chg_cnt + (ADDR_WIDTH+1)'(pix_chg);
`endif
                    if (done) begin
                        bus.converged_out <= (mode_q == 2'd0) && !chg_final;
                        ex <= '0; ey <= '0; ea <= '0;
                        state <= EMIT;
                    end else begin
                        state <= PASS;
                    end
                end
                default: begin
                    bus.pixel_valid_out <= 1'b1;
                    bus.pixel_out       <= src[ea];
                    bus.hcount_out      <= ex;
                    bus.vcount_out      <= ey;
                    ea <= ea + 1'b1;
                    if (ex == X_LAST) begin
                        ex <= '0;
                        ey <= ey + 1'b1;
                    end else begin
                        ex <= ex + 1'b1;
                    end
                    if (ea == A_LAST) state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_thinning_engine.sv
// Directed bench for thinning_engine on an 8x6 frame; a second instance runs with MAX_PASSES=2.
module tb_thinning_engine;
    localparam int H = 8;
    localparam int V = 6;
    localparam int N = H * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    thinning_engine_if #(
        .HWIDTH(3), .VWIDTH(3)
`ifdef THINNING_STATS_EN
        , .ADDR_WIDTH(6)
`endif
    ) if1 (), if2 ();

    thinning_engine #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .bus(if1));
    thinning_engine #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .MAX_PASSES(2)) u_dut2 (
        .clk_in(clk), .rst_n_in(rst_n), .bus(if2));

    assign if2.hcount_in      = if1.hcount_in;
    assign if2.vcount_in      = if1.vcount_in;
    assign if2.pixel_in       = if1.pixel_in;
    assign if2.pixel_valid_in = if1.pixel_valid_in;
    assign if2.mode_in        = if1.mode_in;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] res1, res2;
    int cnt1, cnt2, order_bad;

    always @(negedge clk) begin
        if (if1.pixel_valid_out === 1'b1) begin
            if (int'(if1.vcount_out) * H + int'(if1.hcount_out) != cnt1) order_bad++;
            res1[int'(if1.vcount_out) * H + int'(if1.hcount_out)] = if1.pixel_out;
            cnt1++;
        end
        if (if2.pixel_valid_out === 1'b1) begin
            if (int'(if2.vcount_out) * H + int'(if2.hcount_out) != cnt2) order_bad++;
            res2[int'(if2.vcount_out) * H + int'(if2.hcount_out)] = if2.pixel_out;
            cnt2++;
        end
    end

    task automatic load_frame(input logic [N-1:0] f, input logic [1:0] m);
        cnt1 = 0; cnt2 = 0; order_bad = 0; res1 = '0; res2 = '0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                @(posedge clk); #1;
                if1.pixel_valid_in = 1'b1;
                if1.hcount_in      = 3'(x);
                if1.vcount_in      = 3'(y);
                if1.pixel_in       = f[y*H+x];
                if1.mode_in        = m;
            end
        @(posedge clk); #1;
        if1.pixel_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((if1.busy_out || if2.busy_out) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (if1.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if1.busy_out); end
        total++; if (if1.pixel_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if1.pixel_valid_out); end
        total++; if (if1.pixel_out !== 1'b0) begin bad++; $display("FAIL reset_pixel got=%b want=0", if1.pixel_out); end
        total++; if (if1.hcount_out !== 3'd0) begin bad++; $display("FAIL reset_hcount got=%0d want=0", if1.hcount_out); end
        total++; if (if1.vcount_out !== 3'd0) begin bad++; $display("FAIL reset_vcount got=%0d want=0", if1.vcount_out); end
        total++; if (if1.pass_count_out !== 8'd0) begin bad++; $display("FAIL reset_passes got=%0d want=0", if1.pass_count_out); end
        total++; if (if1.converged_out !== 1'b0) begin bad++; $display("FAIL reset_conv got=%b want=0", if1.converged_out); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_thin_block();
        logic [N-1:0] f, e;
        f = '0; e = '0;
        for (int y = 2; y <= 4; y++) for (int x = 3; x <= 5; x++) f[y*H+x] = 1'b1;
        e[3*H+4] = 1'b1;
        load_frame(f, 2'd0);
        wait_idle();
        total++; if (if1.busy_out !== 1'b0) begin bad++; $display("FAIL thin_timeout busy=%b want=0", if1.busy_out); end
        total++; if (res1 !== e) begin bad++; $display("FAIL thin_frame got=%h want=%h", res1, e); end
        total++; if (if1.pass_count_out !== 8'd3) begin bad++; $display("FAIL thin_passes got=%0d want=3", if1.pass_count_out); end
        total++; if (if1.converged_out !== 1'b1) begin bad++; $display("FAIL thin_conv got=%b want=1", if1.converged_out); end
        total++; if (cnt1 != N) begin bad++; $display("FAIL thin_count got=%0d want=%0d", cnt1, N); end
        total++; if (order_bad != 0) begin bad++; $display("FAIL thin_order errors=%0d want=0", order_bad); end
    endtask

    task automatic test_max_passes();
        load_frame('1, 2'd0);
        wait_idle();
        total++; if (if2.busy_out !== 1'b0) begin bad++; $display("FAIL max_timeout busy=%b want=0", if2.busy_out); end
        total++; if (if2.pass_count_out !== 8'd2) begin bad++; $display("FAIL max_passes got=%0d want=2", if2.pass_count_out); end
        total++; if (if2.converged_out !== 1'b0) begin bad++; $display("FAIL max_conv got=%b want=0", if2.converged_out); end
        total++; if (cnt2 != N) begin bad++; $display("FAIL max_count got=%0d want=%0d", cnt2, N); end
    endtask

    task automatic test_erode();
        logic [N-1:0] f, e;
        f = '0; e = '0;
        for (int y = 1; y <= 4; y++) for (int x = 2; x <= 5; x++) f[y*H+x] = 1'b1;
        for (int y = 2; y <= 3; y++) for (int x = 3; x <= 4; x++) e[y*H+x] = 1'b1;
        load_frame(f, 2'd1);
        wait_idle();
        total++; if (res1 !== e) begin bad++; $display("FAIL erode_frame got=%h want=%h", res1, e); end
        total++; if (if1.pass_count_out !== 8'd1) begin bad++; $display("FAIL erode_passes got=%0d want=1", if1.pass_count_out); end
        total++; if (if1.converged_out !== 1'b0) begin bad++; $display("FAIL erode_conv got=%b want=0", if1.converged_out); end
    endtask

    task automatic test_dilate();
        logic [N-1:0] f, e;
        f = '0; e = '0;
        f[0] = 1'b1;
        e[0] = 1'b1; e[1] = 1'b1; e[H] = 1'b1; e[H+1] = 1'b1;
        load_frame(f, 2'd2);
        wait_idle();
        total++; if (res1 !== e) begin bad++; $display("FAIL dilate_corner got=%h want=%h", res1, e); end
        f = '0; e = '0;
        f[3*H+3] = 1'b1;
        for (int y = 2; y <= 4; y++) for (int x = 2; x <= 4; x++) e[y*H+x] = 1'b1;
        load_frame(f, 2'd2);
        wait_idle();
        total++; if (res1 !== e) begin bad++; $display("FAIL dilate_mid got=%h want=%h", res1, e); end
`ifdef THINNING_STATS_EN
        total++; if (if1.removed_count_out !== 7'd8) begin bad++; $display("FAIL stats_removed got=%0d want=8", if1.removed_count_out); end
`endif
    endtask

    task automatic test_copy_ignore();
        logic [63:0] r;
        logic [N-1:0] f;
        r = {$urandom(), $urandom()};
        f = r[N-1:0];
        load_frame(f, 2'd3);
        // A full inverted frame ending at the last coordinate arrives while busy and must be dropped.
        for (int i = 0; i < N; i++) begin
            if1.pixel_valid_in = 1'b1;
            if1.hcount_in      = 3'(i % H);
            if1.vcount_in      = 3'(i / H);
            if1.pixel_in       = ~f[i];
            if1.mode_in        = 2'd0;
            @(posedge clk); #1;
        end
        if1.pixel_valid_in = 1'b0;
        wait_idle();
        total++; if (res1 !== f) begin bad++; $display("FAIL copy_frame got=%h want=%h", res1, f); end
        total++; if (if1.pass_count_out !== 8'd1) begin bad++; $display("FAIL copy_passes got=%0d want=1", if1.pass_count_out); end
        total++; if (cnt1 != N) begin bad++; $display("FAIL copy_count got=%0d want=%0d", cnt1, N); end
        repeat (4) @(posedge clk); #1;
        total++; if (cnt1 != N) begin bad++; $display("FAIL ignore_restart got=%0d want=%0d", cnt1, N); end
    endtask

    task automatic test_reset_mid_emit();
        logic [63:0] r;
        logic [N-1:0] f;
        int n;
        r = {$urandom(), $urandom()};
        f = r[N-1:0];
        load_frame(f, 2'd3);
        n = 0;
        while (cnt1 < 20 && n < 2000) begin @(posedge clk); #1; n++; end
        total++; if (cnt1 < 20) begin bad++; $display("FAIL midemit_reach got=%0d want>=20", cnt1); end
        rst_n = 1'b0;
        #1;
        total++; if (if1.pixel_valid_out !== 1'b0) begin bad++; $display("FAIL midemit_valid got=%b want=0", if1.pixel_valid_out); end
        total++; if (if1.busy_out !== 1'b0) begin bad++; $display("FAIL midemit_busy got=%b want=0", if1.busy_out); end
        total++; if (if1.hcount_out !== 3'd0 || if1.vcount_out !== 3'd0) begin bad++; $display("FAIL midemit_coord got=%0d,%0d want=0,0", if1.hcount_out, if1.vcount_out); end
        total++; if (if1.pixel_out !== 1'b0) begin bad++; $display("FAIL midemit_pixel got=%b want=0", if1.pixel_out); end
        total++; if (if1.pass_count_out !== 8'd0) begin bad++; $display("FAIL midemit_passes got=%0d want=0", if1.pass_count_out); end
        #13 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        r = {$urandom(), $urandom()};
        f = r[N-1:0];
        load_frame(f, 2'd3);
        wait_idle();
        total++; if (res1 !== f) begin bad++; $display("FAIL after_reset_frame got=%h want=%h", res1, f); end
        total++; if (cnt1 != N) begin bad++; $display("FAIL after_reset_count got=%0d want=%0d", cnt1, N); end
        total++; if (if1.pass_count_out !== 8'd1) begin bad++; $display("FAIL after_reset_passes got=%0d want=1", if1.pass_count_out); end
    endtask

    initial begin
        if1.pixel_valid_in = 1'b0;
        if1.pixel_in       = 1'b0;
        if1.hcount_in      = '0;
        if1.vcount_in      = '0;
        if1.mode_in        = '0;
        test_reset();
        test_thin_block();
        test_max_passes();
        test_erode();
        test_dilate();
        test_copy_ignore();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
